// File: rtl/wfifo_wr_front.sv
// Write-side front end of the async FIFO: 2-entry skid buffer feeding winc/wdata,
// plus a registered pessimistic fill level, almost-full flag and high-water mark.
//
// state    | meaning
// ST_EMPTY | no word buffered, head/skid unused
// ST_ONE   | head holds the oldest (only) word
// ST_TWO   | head holds oldest word, skid holds the next one; s_ready low
module wfifo_wr_front #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  input  logic [DSIZE-1:0]    s_data,
  output logic                s_ready,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   af_thresh,
  input  logic                hwm_clr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   hwm
);

  localparam int PW = ADDRSIZE + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic [PW-1:0]    wlevel_q, hwm_q, hwm_d;
  logic             af_q;

  logic             push, pop;
  logic [PW-1:0]    wbin, rbin, level_c;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          head_d  = s_data;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = s_data;
        end else if (push) begin
          state_d = ST_TWO;
          skid_d  = s_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d = ST_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Outputs decode registers only, so no s_valid/wfull -> s_ready path exists.
  always_comb begin
    s_ready = 1'b0;
    winc    = 1'b0;
    wdata   = head_q;
    s_ready = (state_q != ST_TWO);
    winc    = (state_q != ST_EMPTY) && !wfull;
  end

  assign push = s_valid & s_ready;
  assign pop  = winc;

  // Modular subtraction keeps the level right across pointer wrap.
  assign wbin    = gray2bin(wptr);
  assign rbin    = gray2bin(wq2_rptr);
  assign level_c = wbin - rbin;

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr) begin
      hwm_d = level_c;
    end else if (level_c > hwm_q) begin
      hwm_d = level_c;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q <= '0;
      af_q     <= 1'b0;
      hwm_q    <= '0;
    end else begin
      wlevel_q <= level_c;
      af_q     <= (level_c >= af_thresh);
      hwm_q    <= hwm_d;
    end
  end

  assign wlevel       = wlevel_q;
  assign walmost_full = af_q;
  assign hwm          = hwm_q;

endmodule

// File: tb/tb_wfifo_wr_front.sv
// Directed bench for wfifo_wr_front: scoreboard queue for write order, immediate
// assertions for handshake, level, almost-full and high-water-mark values.
module tb_wfifo_wr_front;

  localparam int DSIZE    = 8;
  localparam int ADDRSIZE = 4;
  localparam int PW       = ADDRSIZE + 1;

  logic              wclk;
  logic              wrst_n;
  logic              s_valid;
  logic [DSIZE-1:0]  s_data;
  logic              s_ready;
  logic              winc;
  logic [DSIZE-1:0]  wdata;
  logic              wfull;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     wq2_rptr;
  logic [PW-1:0]     af_thresh;
  logic              hwm_clr;
  logic [PW-1:0]     wlevel;
  logic              walmost_full;
  logic [PW-1:0]     hwm;

  int n_vec = 0;
  int n_err = 0;
  logic [DSIZE-1:0] sb[$];

  wfifo_wr_front #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .winc         (winc),
    .wdata        (wdata),
    .wfull        (wfull),
    .wptr         (wptr),
    .wq2_rptr     (wq2_rptr),
    .af_thresh    (af_thresh),
    .hwm_clr      (hwm_clr),
    .wlevel       (wlevel),
    .walmost_full (walmost_full),
    .hwm          (hwm)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic set_level(input logic [PW-1:0] lvl);
    wq2_rptr = '0;
    wptr     = bin2gray(lvl);
  endtask

  // Scoreboard: accepted words pushed, written words popped in order.
  always @(negedge wclk) begin
    if (wrst_n) begin
      if (winc) begin
        if (sb.size() == 0) begin
          chk("spurious_winc", 32'(wdata), 32'hFFFF_FFFF);
        end else begin
          chk("wdata_order", 32'(wdata), 32'(sb.pop_front()));
        end
      end
      if (s_valid && s_ready) sb.push_back(s_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset held with random inputs
    wrst_n    = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    wfull     = 1'b0;
    wptr      = '0;
    wq2_rptr  = '0;
    af_thresh = '0;
    hwm_clr   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid   = 1'($urandom);
      s_data    = DSIZE'($urandom);
      wfull     = 1'($urandom);
      wptr      = PW'($urandom);
      wq2_rptr  = PW'($urandom);
      af_thresh = PW'($urandom);
      hwm_clr   = 1'($urandom);
      tick();
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_winc", 32'(winc), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'h00);
      chk("rst_wlevel", 32'(wlevel), 32'd0);
      chk("rst_af", 32'(walmost_full), 32'd0);
      chk("rst_hwm", 32'(hwm), 32'd0);
    end
    s_valid   = 1'b0;
    s_data    = '0;
    wfull     = 1'b0;
    wptr      = '0;
    wq2_rptr  = '0;
    af_thresh = PW'(16);
    hwm_clr   = 1'b0;
    wrst_n    = 1'b1;
    tick();

    // 2: single push, one-cycle latency
    s_valid = 1'b1;
    s_data  = 8'hA5;
    chk("t2_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("t2_winc", 32'(winc), 32'd1);
    chk("t2_wdata", 32'(wdata), 32'hA5);
    tick();
    chk("t2_winc_off", 32'(winc), 32'd0);
    chk("t2_ready_empty", 32'(s_ready), 32'd1);

    // 3: back-pressure fills the skid buffer, release drains in order
    wfull   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h01;
    tick();
    chk("t3_ready_one", 32'(s_ready), 32'd1);
    chk("t3_winc_full", 32'(winc), 32'd0);
    s_data = 8'h02;
    tick();
    chk("t3_ready_two", 32'(s_ready), 32'd0);
    s_data = 8'h03;
    tick();
    chk("t3_ready_hold", 32'(s_ready), 32'd0);
    chk("t3_head_hold", 32'(wdata), 32'h01);
    wfull = 1'b0;
    #1;
    chk("t3_drain0_winc", 32'(winc), 32'd1);
    chk("t3_drain0_data", 32'(wdata), 32'h01);
    tick();
    chk("t3_drain1_winc", 32'(winc), 32'd1);
    chk("t3_drain1_data", 32'(wdata), 32'h02);
    chk("t3_ready_back", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("t3_drain2_winc", 32'(winc), 32'd1);
    chk("t3_drain2_data", 32'(wdata), 32'h03);
    tick();
    chk("t3_idle", 32'(winc), 32'd0);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // throughput: back-to-back stream with wfull=0
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = DSIZE'($urandom);
      chk("tp_ready", 32'(s_ready), 32'd1);
      tick();
      chk("tp_winc", 32'(winc), 32'd1);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    chk("tp_sb_empty", 32'(sb.size()), 32'd0);

    // 4: level, plain and across pointer wrap
    wptr     = 5'b01111;
    wq2_rptr = 5'b00010;
    tick();
    chk("t4_level", 32'(wlevel), 32'd7);
    chk("t4_af", 32'(walmost_full), 32'd0);
    chk("t4_hwm", 32'(hwm), 32'd7);
    wptr     = 5'b00011;
    wq2_rptr = 5'b10001;
    tick();
    chk("t4_wrap_level", 32'(wlevel), 32'd4);
    chk("t4_hwm_keep", 32'(hwm), 32'd7);

    // 5: almost-full threshold and high-water mark
    af_thresh = PW'(12);
    set_level(PW'(11));
    tick();
    chk("t5_l11", 32'(wlevel), 32'd11);
    chk("t5_af11", 32'(walmost_full), 32'd0);
    chk("t5_hwm11", 32'(hwm), 32'd11);
    set_level(PW'(12));
    tick();
    chk("t5_l12", 32'(wlevel), 32'd12);
    chk("t5_af12", 32'(walmost_full), 32'd1);
    chk("t5_hwm12", 32'(hwm), 32'd12);
    set_level(PW'(5));
    hwm_clr = 1'b1;
    tick();
    hwm_clr = 1'b0;
    chk("t5_l5", 32'(wlevel), 32'd5);
    chk("t5_af5", 32'(walmost_full), 32'd0);
    chk("t5_hwm_clr", 32'(hwm), 32'd5);
    set_level(PW'(9));
    tick();
    chk("t5_hwm9", 32'(hwm), 32'd9);
    set_level(PW'(6));
    tick();
    chk("t5_hwm_hold", 32'(hwm), 32'd9);
    set_level(PW'(16));
    tick();
    chk("t5_level_full", 32'(wlevel), 32'd16);
    chk("t5_af_full", 32'(walmost_full), 32'd1);
    af_thresh = '0;
    set_level(PW'(0));
    tick();
    chk("t5_af_zero", 32'(walmost_full), 32'd1);
    chk("t5_level_zero", 32'(wlevel), 32'd0);
    af_thresh = PW'(16);

    // 6: reset while TWO entries are buffered
    wfull   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h11;
    tick();
    s_data = 8'h22;
    tick();
    s_valid = 1'b0;
    chk("t6_two", 32'(s_ready), 32'd0);
    wfull = 1'b0;
    #1;
    chk("t6_winc_pre", 32'(winc), 32'd1);
    wrst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_winc", 32'(winc), 32'd0);
    chk("t6_rst_ready", 32'(s_ready), 32'd1);
    chk("t6_rst_wdata", 32'(wdata), 32'h00);
    tick();
    wrst_n  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h3C;
    tick();
    s_valid = 1'b0;
    chk("t6_first_winc", 32'(winc), 32'd1);
    chk("t6_first_data", 32'(wdata), 32'h3C);
    tick();
    chk("t6_after_winc", 32'(winc), 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
